// File: rtl/wb_mdio_master_pkg.sv
// wb_mdio_master_pkg: clause-22 MDIO frame constants, FSM states and frame builder
package wb_mdio_master_pkg;
  localparam logic [1:0] MDIO_ST       = 2'b01;
  localparam logic [1:0] MDIO_OP_WRITE = 2'b01;
  localparam logic [1:0] MDIO_OP_READ  = 2'b10;
  localparam logic [1:0] MDIO_TA_WRITE = 2'b10;
  typedef enum logic [1:0] {IDLE, PRE, FRAME, DONE} state_t;
  function automatic logic [31:0] mdio_frame(input logic we, input logic [9:0] addr, input logic [15:0] data);
    return {MDIO_ST, we ? MDIO_OP_WRITE : MDIO_OP_READ, addr, we ? MDIO_TA_WRITE : 2'b11, data};
  endfunction
endpackage

// File: rtl/mdio_clkgen.sv
// mdio_clkgen: MDC divider with strobes marking the cycle in which mdc rises or falls
module mdio_clkgen #(
  parameter int DIV = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic mdc,
  output logic rise,
  output logic fall
);
  localparam int W = $clog2(DIV) + 1;
  logic [W-1:0] cnt;
  logic tc;
  assign tc   = en && cnt == W'(DIV - 1);
  assign rise = tc && !mdc;
  assign fall = tc && mdc;
  // count half-periods while enabled; mdc parks low when disabled
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (tc) begin
      cnt <= '0;
      mdc <= ~mdc;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/wb_mdio_master.sv
// wb_mdio_master: Wishbone classic slave issuing one clause-22 MDIO frame per access
module wb_mdio_master
  import wb_mdio_master_pkg::*;
#(
  parameter int DIV      = 8,
  parameter bit PREAMBLE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [9:0]  wb_addr,
  input  logic [15:0] wb_data_write,
  output logic        wb_ack,
  output logic        wb_err,
  output logic [15:0] wb_data_read,
  output logic        mdc,
  input  logic        mdi,
  output logic        mdo,
  output logic        mdo_oe
);
  state_t state;
  logic [4:0] bit_cnt;
  logic [31:0] sr;
  logic [31:0] frame_in;
  logic [15:0] rd_sr;
  logic we_q, ta_err, abort, clk_en, mdc_rise, mdc_fall;
  assign frame_in = mdio_frame(wb_we, wb_addr, wb_data_write);
  assign clk_en   = state == PRE || state == FRAME;
  mdio_clkgen #(.DIV(DIV)) u_clkgen (
    .clk (clk),
    .rst (rst),
    .en  (clk_en),
    .mdc (mdc),
    .rise(mdc_rise),
    .fall(mdc_fall)
  );
  // frame sequencer: launches bits on mdc fall, samples the PHY on mdc rise
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      sr           <= '0;
      rd_sr        <= '0;
      we_q         <= 1'b0;
      ta_err       <= 1'b0;
      abort        <= 1'b0;
      mdo          <= 1'b1;
      mdo_oe       <= 1'b0;
      wb_ack       <= 1'b0;
      wb_err       <= 1'b0;
      wb_data_read <= '0;
    end else begin
      wb_ack <= 1'b0;
      wb_err <= 1'b0;
      if (state != IDLE && !wb_cyc) abort <= 1'b1;
      case (state)
        IDLE: if (wb_cyc && wb_stb && !wb_ack && !wb_err) begin
          state   <= PREAMBLE ? PRE : FRAME;
          sr      <= frame_in;
          we_q    <= wb_we;
          abort   <= 1'b0;
          ta_err  <= 1'b0;
          bit_cnt <= '0;
          mdo     <= PREAMBLE ? 1'b1 : frame_in[31];
          mdo_oe  <= 1'b1;
        end
        PRE: if (mdc_fall) begin
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == 5'd31) begin
            state <= FRAME;
            mdo   <= sr[31];
          end
        end
        FRAME: begin
          if (mdc_rise && !we_q) begin
            if (bit_cnt == 5'd15) ta_err <= mdi;
            if (bit_cnt[4]) rd_sr <= {rd_sr[14:0], mdi};
          end
          if (mdc_fall) begin
            bit_cnt <= bit_cnt + 1'b1;
            sr      <= sr << 1;
            mdo     <= bit_cnt == 5'd31 ? 1'b1 : sr[30];
            mdo_oe  <= bit_cnt != 5'd31 && (we_q || bit_cnt < 5'd13);
            if (bit_cnt == 5'd31) state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
          if (!abort && wb_cyc) begin
            wb_ack <= we_q || !ta_err;
            wb_err <= !we_q && ta_err;
            if (!we_q && !ta_err) wb_data_read <= rd_sr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_mdio_master.sv
// tb_wb_mdio_master: directed checks of MDIO framing, turnaround, latency, abort and reset
module tb_wb_mdio_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cyc_a = 1'b0, stb_a = 1'b0, cyc_b = 1'b0, stb_b = 1'b0;
  logic we = 1'b0;
  logic [9:0] addr = '0;
  logic [15:0] wdat = '0;
  logic ack_a, err_a, mdc_a, mdo_a, oe_a, mdi_a;
  logic ack_b, err_b, mdc_b, mdo_b, oe_b, mdi_b;
  logic [15:0] rd_a, rd_b;
  logic phy_on = 1'b0;
  logic [15:0] rdval = '0;
  int rcnt = 0, rcnt_b = 0, ncyc = 0, base = 0;
  int acks_a = 0, errs_a = 0, acks_b = 0;
  int passed = 0, total = 0;
  logic mdc_a_d = 1'b0, mdc_b_d = 1'b0;
  logic bo [1024];
  logic boe [1024];
  logic bb [64];
  logic bbo [64];
  int rtb [64];
  int fj;

  always #5 clk = ~clk;

  wb_mdio_master #(.DIV(2), .PREAMBLE(1'b1)) dut_a (
    .clk(clk), .rst(rst), .wb_cyc(cyc_a), .wb_stb(stb_a), .wb_we(we), .wb_addr(addr),
    .wb_data_write(wdat), .wb_ack(ack_a), .wb_err(err_a), .wb_data_read(rd_a),
    .mdc(mdc_a), .mdi(mdi_a), .mdo(mdo_a), .mdo_oe(oe_a)
  );

  wb_mdio_master #(.DIV(1), .PREAMBLE(1'b0)) dut_b (
    .clk(clk), .rst(rst), .wb_cyc(cyc_b), .wb_stb(stb_b), .wb_we(we), .wb_addr(addr),
    .wb_data_write(wdat), .wb_ack(ack_b), .wb_err(err_b), .wb_data_read(rd_b),
    .mdc(mdc_b), .mdi(mdi_b), .mdo(mdo_b), .mdo_oe(oe_b)
  );

  assign mdi_b = 1'b1;

  // PHY model: index of the rise being sampled is rcnt - base; TA is Z (pulled high) then 0
  always_comb begin
    fj = rcnt - base - 32;
    mdi_a = 1'b1;
    if (phy_on && fj == 15) mdi_a = 1'b0;
    if (phy_on && fj >= 16 && fj <= 31) mdi_a = rdval[4'(31 - fj)];
  end

  // wire monitor: record mdo/mdo_oe at each mdc rise and count response pulses
  always @(negedge clk) begin
    ncyc <= ncyc + 1;
    mdc_a_d <= mdc_a;
    mdc_b_d <= mdc_b;
    if (mdc_a && !mdc_a_d) begin
      if (rcnt < 1024) begin
        bo[rcnt] <= mdo_a;
        boe[rcnt] <= oe_a;
      end
      rcnt <= rcnt + 1;
    end
    if (mdc_b && !mdc_b_d) begin
      if (rcnt_b < 64) begin
        bb[rcnt_b] <= mdo_b;
        bbo[rcnt_b] <= oe_b;
        rtb[rcnt_b] <= ncyc;
      end
      rcnt_b <= rcnt_b + 1;
    end
    if (ack_a) acks_a <= acks_a + 1;
    if (err_a) errs_a <= errs_a + 1;
    if (ack_b) acks_b <= acks_b + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] word_at(input int s);
    logic [31:0] w = '0;
    for (int i = 0; i < 32; i++) w = {w[30:0], (s + i < 1024) ? bo[s + i] : 1'bx};
    return w;
  endfunction

  task automatic run(input logic sel_b, input logic w, input logic [9:0] a, input logic [15:0] d, output int lat);
    we = w;
    addr = a;
    wdat = d;
    base = rcnt;
    cyc_a = !sel_b;
    stb_a = !sel_b;
    cyc_b = sel_b;
    stb_b = sel_b;
    lat = -1;
    for (int i = 1; i <= 3000; i++) begin
      @(negedge clk);
      if (sel_b ? (ack_b || err_b) : (ack_a || err_a)) begin
        lat = i - 1;
        break;
      end
    end
    cyc_a = 1'b0;
    stb_a = 1'b0;
    cyc_b = 1'b0;
    stb_b = 1'b0;
    if (lat < 0) check("txn_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rises(input int n);
    int i = 0;
    while (rcnt - base < n && i < 5000) begin
      @(negedge clk);
      i++;
    end
    if (i >= 5000) check("rise_timeout", 32'(rcnt - base), 32'(n));
  endtask

  initial begin
    int lat, a0, e0, b0, n;
    logic [31:0] w;
    repeat (3) @(negedge clk);
    check("rst_mdc", mdc_a, 1'b0);
    check("rst_mdo", mdo_a, 1'b1);
    check("rst_oe", oe_a, 1'b0);
    check("rst_ack", ack_a, 1'b0);
    check("rst_err", err_a, 1'b0);
    check("rst_rd", rd_a, 16'h0000);
    check("rst_mdc_b", mdc_b, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    a0 = acks_a; e0 = errs_a;
    run(1'b0, 1'b1, 10'h0A3, 16'h1234, lat);
    repeat (4) @(negedge clk);
    check("w_lat", 32'(lat), 32'd257);
    check("w_ack_cnt", 32'(acks_a - a0), 32'd1);
    check("w_err_cnt", 32'(errs_a - e0), 32'd0);
    check("w_nbits", 32'(rcnt - base), 32'd64);
    check("w_preamble", word_at(base), 32'hFFFFFFFF);
    check("w_frame", word_at(base + 32), 32'h528E1234);
    n = 0;
    for (int i = 0; i < 64; i++) n += int'(boe[base + i]);
    check("w_oe_bits", 32'(n), 32'd64);
    check("w_idle_oe", oe_a, 1'b0);
    phy_on = 1'b1;
    rdval = 16'hBEEF;
    a0 = acks_a; e0 = errs_a;
    run(1'b0, 1'b0, 10'h0A3, 16'h0000, lat);
    repeat (4) @(negedge clk);
    w = word_at(base + 32);
    check("r_lat", 32'(lat), 32'd257);
    check("r_ack_cnt", 32'(acks_a - a0), 32'd1);
    check("r_err_cnt", 32'(errs_a - e0), 32'd0);
    check("r_data", rd_a, 16'hBEEF);
    check("r_hdr", w[31:18], 14'h18A3);
    check("r_oe_bit13", boe[base + 45], 1'b1);
    check("r_oe_bit14", boe[base + 46], 1'b0);
    check("r_oe_bit31", boe[base + 63], 1'b0);
    phy_on = 1'b0;
    a0 = acks_a; e0 = errs_a;
    run(1'b0, 1'b0, 10'h041, 16'h0000, lat);
    repeat (4) @(negedge clk);
    check("nophy_err_cnt", 32'(errs_a - e0), 32'd1);
    check("nophy_ack_cnt", 32'(acks_a - a0), 32'd0);
    check("nophy_rd_hold", rd_a, 16'hBEEF);
    check("nophy_lat", 32'(lat), 32'd257);
    a0 = acks_a; e0 = errs_a;
    we = 1'b1;
    addr = 10'h3FF;
    wdat = 16'hA5C3;
    base = rcnt;
    cyc_a = 1'b1;
    stb_a = 1'b1;
    wait_rises(40);
    cyc_a = 1'b0;
    stb_a = 1'b0;
    addr = 10'h000;
    wdat = 16'h0000;
    wait_rises(64);
    repeat (10) @(negedge clk);
    check("abort_ack_cnt", 32'(acks_a - a0), 32'd0);
    check("abort_err_cnt", 32'(errs_a - e0), 32'd0);
    check("abort_nbits", 32'(rcnt - base), 32'd64);
    check("abort_frame", word_at(base + 32), 32'h5FFEA5C3);
    check("abort_idle_oe", oe_a, 1'b0);
    a0 = acks_a;
    run(1'b0, 1'b1, 10'h001, 16'hFFFF, lat);
    repeat (4) @(negedge clk);
    check("post_abort_lat", 32'(lat), 32'd257);
    check("post_abort_ack", 32'(acks_a - a0), 32'd1);
    phy_on = 1'b1;
    rdval = 16'hCAFE;
    we = 1'b0;
    addr = 10'h0A3;
    base = rcnt;
    cyc_a = 1'b1;
    stb_a = 1'b1;
    wait_rises(20);
    a0 = acks_a;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_mdc", mdc_a, 1'b0);
    check("midrst_mdo", mdo_a, 1'b1);
    check("midrst_oe", oe_a, 1'b0);
    check("midrst_ack", ack_a, 1'b0);
    rst = 1'b0;
    cyc_a = 1'b0;
    stb_a = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_ack_cnt", 32'(acks_a - a0), 32'd0);
    rdval = 16'h0001;
    a0 = acks_a; e0 = errs_a;
    run(1'b0, 1'b0, 10'h0A3, 16'h0000, lat);
    repeat (4) @(negedge clk);
    check("post_rst_ack", 32'(acks_a - a0), 32'd1);
    check("post_rst_err", 32'(errs_a - e0), 32'd0);
    check("post_rst_data", rd_a, 16'h0001);
    b0 = acks_b;
    run(1'b1, 1'b1, 10'h0A3, 16'h1234, lat);
    repeat (4) @(negedge clk);
    check("b_lat", 32'(lat), 32'd65);
    check("b_ack_cnt", 32'(acks_b - b0), 32'd1);
    check("b_nbits", 32'(rcnt_b), 32'd32);
    check("b_start_bit0", bb[0], 1'b0);
    check("b_start_bit1", bb[1], 1'b1);
    check("b_oe_first", bbo[0], 1'b1);
    check("b_mdc_period", 32'(rtb[1] - rtb[0]), 32'd2);
    w = '0;
    for (int i = 0; i < 32; i++) w = {w[30:0], bb[i]};
    check("b_frame", w, 32'h528E1234);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
